// File: rtl/magnetron_ctrl.sv
// magnetron_ctrl: microwave cook controller with door interlock, one-second
// cook ticks and one-cycle set/reset pulses for an external magnetron SR latch.
// Optional feature: define MAGNETRON_PAUSE_EN to enable pause/resume support.
// Without the macro, stop or an opened door cancels a cook outright.
module magnetron_ctrl #(
    parameter int unsigned TICK_CYCLES = 50000000,
    parameter int unsigned TIME_W      = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              door_closed,
    input  logic              start,
    input  logic              stop,
    input  logic              load,
    input  logic [TIME_W-1:0] load_sec,
    output logic              mag_set,
    output logic              mag_reset,
    output logic [TIME_W-1:0] time_left,
    output logic [1:0]        state,
    output logic              done
);

    localparam int unsigned PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COOKING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [TIME_W-1:0] time_left_q, time_left_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              mag_set_q, mag_set_d;
    logic              mag_reset_q, mag_reset_d;
    logic              done_q, done_d;
    logic              tick;

    // Next-state, timer and prescaler; latch pulses derive from the state change
    // so they land in the same cycle the new state becomes visible.
    always_comb begin
        state_d     = state_q;
        time_left_d = time_left_q;
        presc_d     = presc_q;
        tick        = (presc_q == PW'(TICK_CYCLES - 1));

        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                // Door/stop have no action of their own here; an accepted start
                // outranks a simultaneous load.
                if (start && door_closed && (time_left_q != '0)) begin
                    state_d = ST_COOKING;
                end else if (load) begin
                    time_left_d = load_sec;
                end
            end
            ST_COOKING: begin
                if (!door_closed || stop) begin
`ifdef MAGNETRON_PAUSE_EN
                    state_d = ST_PAUSED;
`else
                    state_d     = ST_IDLE;
                    time_left_d = '0;
                    presc_d     = '0;
`endif
                end else if (tick) begin
                    presc_d = '0;
                    if (time_left_q > TIME_W'(1)) begin
                        time_left_d = time_left_q - TIME_W'(1);
                    end else begin
                        time_left_d = '0;
                        state_d     = ST_DONE;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_PAUSED: begin
`ifdef MAGNETRON_PAUSE_EN
                if (stop) begin
                    state_d     = ST_IDLE;
                    time_left_d = '0;
                    presc_d     = '0;
                end else if (start && door_closed) begin
                    state_d = ST_COOKING;
                end
`else
                state_d     = ST_IDLE;
                time_left_d = '0;
                presc_d     = '0;
`endif
            end
            default: begin
                presc_d = '0;
                if (!door_closed || stop || load) begin
                    state_d = ST_IDLE;
                end
                if (load) begin
                    time_left_d = load_sec;
                end
            end
        endcase

        mag_set_d   = (state_d == ST_COOKING) && (state_q != ST_COOKING);
        mag_reset_d = (state_q == ST_COOKING) && (state_d != ST_COOKING);
        done_d      = (state_d == ST_DONE);
    end

    // State and output registers; reset holds the magnetron latch forced off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            time_left_q <= '0;
            presc_q     <= '0;
            mag_set_q   <= 1'b0;
            mag_reset_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_left_q <= time_left_d;
            presc_q     <= presc_d;
            mag_set_q   <= mag_set_d;
            mag_reset_q <= mag_reset_d;
            done_q      <= done_d;
        end
    end

    assign mag_set   = mag_set_q;
    assign mag_reset = mag_reset_q;
    assign time_left = time_left_q;
    assign state     = state_q;
    assign done      = done_q;

endmodule

// File: doc/magnetron_ctrl.md
MAGNETRON_CTRL -- requirements
Module: magnetron_ctrl

Interface
REQ-001 Parameter TICK_CYCLES, default 50000000, is the number of clk cycles per one-second cook tick (minimum 2).
REQ-002 Parameter TIME_W, default 13, is the width of the cook-time count in seconds (max 5999 = 99:59).
REQ-003 Port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 Port rst  input  1  asynchronous active-high reset.
REQ-005 Port door_closed  input  1  1 = door shut; 0 = open (safety interlock).
REQ-006 Port start  input  1  one-cycle start/resume request.
REQ-007 Port stop  input  1  one-cycle stop/cancel request.
REQ-008 Port load  input  1  one-cycle load of load_sec into the cook timer.
REQ-009 Port load_sec  input  TIME_W  cook time in seconds, sampled when load=1.
REQ-010 Port mag_set  output  1  one-cycle pulse to the magnetron SR latch set input.
REQ-011 Port mag_reset  output  1  one-cycle pulse to the magnetron SR latch reset input.
REQ-012 Port time_left  output  TIME_W  remaining cook seconds.
REQ-013 Port state  output  2  00 IDLE, 01 COOKING, 10 PAUSED, 11 DONE.
REQ-014 Port done  output  1  high while in DONE.

Function
REQ-015 All outputs SHALL be registered; mag_set and mag_reset are never high in the same cycle.
REQ-016 Per-cycle input priority SHALL be: door_closed=0, then stop, then tick expiry, then start, then load.
REQ-017 IDLE: load=1 -> time_left<=load_sec; start=1 with door_closed=1 and time_left!=0 -> COOKING; start with time_left==0 ignored.
REQ-018 Entry to COOKING SHALL pulse mag_set for exactly one cycle, in the cycle state first reads 01.
REQ-019 Any exit from COOKING SHALL pulse mag_reset for exactly one cycle, in the cycle state first reads the new value.
REQ-020 Prescaler counts 0..TICK_CYCLES-1 only in COOKING, holds in PAUSED, clears in IDLE and DONE; a tick occurs on the wrap from TICK_CYCLES-1 to 0.
REQ-021 COOKING tick with time_left>1 -> time_left decrements by 1; tick with time_left==1 -> time_left<=0, state DONE.
REQ-022 COOKING: load and start SHALL be ignored.
REQ-023 DONE: stop, load or door_closed=0 -> IDLE; load in DONE also loads load_sec; start ignored.
REQ-024 time_left SHALL never underflow below 0.

Reset
REQ-025 While rst=1: state=IDLE, time_left=0, prescaler=0, mag_set=0, done=0, mag_reset=1 (forces latch off).
REQ-026 mag_reset SHALL drop to 0 on the first clk edge after rst deasserts; rst mid-cook aborts immediately, no mag_set pulse follows.

Configuration
REQ-027 Macro MAGNETRON_PAUSE_EN SHALL select pause support.
REQ-028 With MAGNETRON_PAUSE_EN: COOKING with stop or door_closed=0 -> PAUSED, time_left and prescaler held; PAUSED start with door_closed=1 -> COOKING (mag_set pulse); PAUSED stop -> IDLE, time_left<=0; PAUSED load ignored.
REQ-029 Without MAGNETRON_PAUSE_EN: PAUSED unreachable; COOKING with stop or door_closed=0 -> IDLE, time_left<=0.

Verification (TICK_CYCLES=4)
REQ-030 Reset: rst=1 -> mag_reset=1, state=00, time_left=0; release -> mag_reset=0 after one edge.
REQ-031 Load 3, start, door shut -> one mag_set pulse, time_left 3,2,1,0 at 4-cycle spacing, then state=11, done=1, one mag_reset pulse; stop -> state=00.
REQ-032 Start with time_left=0 or door open -> no mag_set pulse, state stays 00.
REQ-033 With MAGNETRON_PAUSE_EN: load 5, cook 2 ticks, door open -> mag_reset pulse, state=10, time_left=3 held; door shut + start -> mag_set pulse, cooking resumes from 3.
REQ-034 Without MAGNETRON_PAUSE_EN: load 5, cook 1 tick, stop -> mag_reset pulse, state=00, time_left=0.
REQ-035 Stop and tick expiry in the same cycle with time_left=1 -> stop wins (PAUSED or IDLE per macro), not DONE; rst asserted mid-cook -> immediate mag_reset=1, state=00.
